// File: rtl/tappy_fifo_if.sv
// tappy_fifo_if: valid/ready byte stream from the tappy capture FIFO to its consumer.
interface tappy_fifo_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/tappy_fifo.sv
// tappy_fifo: captures one decoded byte per rising edge of done into a small FIFO,
// drained through a valid/ready stream, with occupancy and sticky overflow reporting.
module tappy_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       sysclk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           word,
    input  logic                       done,
    tappy_fifo_if.master               out_if,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, full, wr_en, ovf_set;

    always_comb begin
        push       = done & ~done_q;
        pop        = (count_q != '0) & out_if.out_ready;
        full       = count_q == CW'(DEPTH);
        // At full, a concurrent pop frees the slot the push needs.
        wr_en      = push & (~full | pop);
        ovf_set    = push & full & ~pop;
        done_d     = done;
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(wr_en) - CW'(pop);
        overflow_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
    end

    // done_q resets high so a done already asserted at reset release is not a new edge.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (wr_en) mem[wr_ptr_q] <= word;
    end

    assign out_if.out_valid = count_q != '0;
    assign out_if.out_data  = out_if.out_valid ? mem[rd_ptr_q] : '0;
    assign count            = count_q;
    assign overflow         = overflow_q;
endmodule

// File: doc/tappy_fifo.md
Name: tappy_fifo

Overview:
- Downstream consumer of the tappy serial decoder.
- Captures each decoded byte presented on word/done into a small synchronous FIFO in the sysclk domain.
- Presents captured bytes to later logic through a valid/ready handshake, decoupling consumer stalls from the serial line rate.
- Reports occupancy and a sticky overflow flag for bytes lost while full.

Parameters:
- WIDTH, 8, bits per captured word; matches the decoder's byte output.
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- sysclk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- word  input  WIDTH  decoded byte from the tappy decoder; valid while done=1.
- done  input  1  decoder completion flag; pulse or level, one or more sysclk cycles.
- out_data  output  WIDTH  head-of-FIFO byte.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- count  output  $clog2(DEPTH)+1  number of entries held, 0..DEPTH.
- overflow  output  1  sticky: at least one byte dropped because the FIFO was full.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - rd_ptr, wr_ptr, count = 0.
  - out_valid = 0, overflow = 0.
  - done_q (registered copy of done) = 1, so a done held high across reset release is not captured.
  - Storage array is not reset.
- Capture event (push): done=1 & done_q=0 at a sysclk posedge.
  - Exactly one push per done rising edge regardless of how long done stays high.
  - word is sampled at that same edge.
- Pop: out_valid=1 & out_ready=1 at a posedge.
  - rd_ptr advances; count decrements.
- Write path: on push with room, mem[wr_ptr] <= word, wr_ptr+1, count+1.
  - Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Latency: a byte pushed at edge N is visible on out_data with out_valid=1 after edge N (registered, no same-edge fall-through).
- out_valid = (count != 0), derived from the registered count.
- out_data = mem[rd_ptr] when out_valid=1, else all zeros.
- Full (count == DEPTH):
  - push without a simultaneous pop: byte dropped, pointers and count unchanged, overflow <= 1.
  - push with a simultaneous pop: both take effect, count stays DEPTH, no overflow.
- Empty (count == 0): out_ready is ignored and no pop occurs. A push at the same edge is a plain push; the byte is not bypassed to out_data that cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Overflow priority: ovf_clr and a new overflow event at the same edge leave overflow = 1 (set wins). Otherwise ovf_clr drives overflow to 0.
- Mid-operation reset: all contents are discarded immediately; out_valid falls asynchronously with reset_n.
- Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count == DEPTH when the pointers are equal and the FIFO is full.

Test Plan:
- Reset, then done pulse (1 cycle) with word=8'hA5, out_ready=0 -> one edge later out_valid=1, out_data=8'hA5, count=1; with out_ready=1 for one cycle -> count=0, out_valid=0, out_data=0.
- done held high 20 cycles with word=8'h3C -> exactly one entry captured (count=1); drop done and re-raise with word=8'h3D -> count=2, read order 3C then 3D.
- Nine separate done pulses with words 1..9, out_ready=0, DEPTH=8 -> count=8, overflow=1, drain yields 1..8 in order; assert ovf_clr -> overflow=0.
- Fill to 8 entries, then push word=8'h77 at the same edge as a pop with out_ready=1 -> count stays 8, overflow stays 0, 8'h77 is read last after 7 further pops.
- done=1 while reset_n deasserts -> no capture, count=0; done low then high with word=8'h11 -> count=1, out_data=8'h11.
- Load 3 entries, assert reset_n=0 mid-cycle -> out_valid=0 and count=0 immediately; after release, out_valid stays 0 until the next done edge.
